rvc_fetch_aligner: RTL and testbench
====================================

# rvc_fetch_aligner

Sequencer between the instruction-fetch port and decode that splits 32-bit fetch words into 16-bit compressed and 32-bit full RVC instructions. It buffers a leftover upper halfword and tracks the instruction PC. Each cycle it emits the alignment class (f1f1, f1f2, hf, fh, hh) and stall_compressed that drive the compressed-PC correction logic. Sits in the IF stage, ahead of the decompressor.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch_data is a valid word.
- fetch_data  in  32  word at a 4-byte-aligned address.
- fetch_ready  out  1  word consumed this cycle.
- redirect  in  1  branch/jump/trap redirect.
- redirect_pc  in  32  redirect target, 2-byte aligned.
- instr_valid  out  1  instruction presented.
- instr_ready  in  1  decode accepts.
- instr  out  32  instruction; compressed is zero-extended as {16'h0, half}.
- instr_pc  out  32  PC of instr.
- instr_is_compressed  out  1  instr[1:0] != 2'b11.
- f1f1, f1f2, hf, fh, hh  out  1 each  alignment class, one-hot when instr_valid, else 0.
- stall_compressed  out  1  instruction taken from buffer, fetch held.

## Operation
- A half is compressed iff half[1:0] != 2'b11. lo = fetch_data[15:0], hi = fetch_data[31:16]. buf is a 16-bit register. pc_q is a 32-bit register.
- Outputs are combinational from state, buf and fetch_data. The instruction is accepted (fire) when instr_valid & instr_ready.
- **ALIGNED:**
  - lo full: emit fetch_data with f1f1. Stay in ALIGNED.
  - lo compressed, hi compressed: emit lo with hh. buf <= hi. Go to HI_COMP.
  - lo compressed, hi full: emit lo with hf. buf <= hi. Go to SPAN.
- **SPAN:** emit {lo, buf} as a full instruction.
  - hi compressed: class fh. buf <= hi. Go to HI_COMP.
  - hi full: class f1f2. buf <= hi. Stay in SPAN.
- **HI_COMP:** emit {16'h0, buf} with hh and stall_compressed=1. fetch_ready=0; fetch_valid is ignored. On fire, go to ALIGNED.
- **SKIP_LO** (after redirect to pc[1]=1): lo is discarded.
  - hi compressed: emit hi with hh. Go to ALIGNED.
  - hi full: instr_valid=0, fetch_ready=1. buf <= hi. Go to SPAN.
- In ALIGNED and SPAN: instr_valid = fetch_valid and fetch_ready = fire. In SKIP_LO with hi compressed, fetch_ready = fire.
- On each fire, pc_q advances by 2 (compressed) or 4 (full). instr_pc = pc_q. Addition wraps modulo 2^32.
- **redirect** has priority over everything:
  - That cycle: instr_valid=0 and fetch_ready=0.
  - Next cycle: pc_q <= redirect_pc, buf is discarded, state <= redirect_pc[1] ? SKIP_LO : ALIGNED.
  - The fetch unit supplies the word at {redirect_pc[31:2], 2'b00}.
- **Backpressure:** with instr_ready=0, state, buf and pc_q hold and the outputs stay stable while fetch_data is stable.

## Timing
- Reset: state=ALIGNED, buf=0, pc_q=RESET_PC. On the first cycle after reset deasserts, instr_valid=0 unless fetch_valid=1.
- Latency fetch_valid -> instr_valid is 0 cycles (combinational). State, buf and pc_q update on the fire edge.
- A word holding two compressed instructions takes 2 cycles; fetch_ready is low in the second.
- A redirect in any state, including mid-SPAN or HI_COMP, cancels the buffered half. No instruction is emitted during the redirect cycle.
- Reset mid-operation behaves like power-on reset, including over a concurrent redirect.

## Structure
- Package rvc_pkg:
  - typedef enum logic [1:0] align_state_t {ALIGNED, SPAN, HI_COMP, SKIP_LO}.
  - localparam OPC_FULL = 2'b11.
  - function is_rvc(logic [15:0]).
- Single flat module; no sub-module needed. The class outputs connect directly to pc_corrector alongside instr_pc.

## Test plan
- **Full aligned:** reset, then word 32'h0010_0093 with instr_ready=1 -> instr=32'h0010_0093, instr_pc=0, f1f1=1, fetch_ready=1; pc_q becomes 4.
- **Two compressed in one word:** word 32'h4505_4501 ->
  - cycle 1: instr=32'h0000_4501, pc 0, hh=1.
  - cycle 2: instr=32'h0000_4505, pc 2, stall_compressed=1, fetch_ready=0.
  - pc_q becomes 4.
- **Spanning full instruction:** words 32'h0093_4501 then 32'h4505_0010 ->
  - 4501 @0 with hf.
  - 32'h0010_0093 @2 with fh.
  - 4505 @6 from HI_COMP.
  - pc_q becomes 8.
- **Redirect to halfword target:** redirect_pc=32'h102, then word 32'h4505_4501 -> single instr 32'h0000_4505 @0x102 (lo dropped); pc_q becomes 0x104.
- **Redirect mid-span:** in SPAN, redirect to 32'h200 -> buf discarded; next word 32'h0000_0013 emits 32'h0000_0013 @0x200 with f1f1.
- **Backpressure:** instr_ready=0 for 3 cycles in SPAN -> fetch_ready=0; instr, instr_pc and fh stay constant. With instr_ready=1, a single fire occurs.

Source files
------------

// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared types and helpers for the RVC fetch aligner: alignment state encoding
// and the compressed-halfword test.
package rvc_pkg;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        SPAN    = 2'd1,
        HI_COMP = 2'd2,
        SKIP_LO = 2'd3
    } align_state_t;

    localparam logic [1:0] OPC_FULL = 2'b11;

    function automatic logic is_rvc(input logic [15:0] half);
        return (half[1:0] != OPC_FULL);
    endfunction

endpackage

// File: rtl/rvc_fetch_aligner.sv
// Splits 4-byte-aligned fetch words into 16/32-bit RVC instructions, carrying a
// leftover upper halfword across words and tracking the instruction PC.
module rvc_fetch_aligner
    import rvc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    output logic        fetch_ready_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_compressed_o,
    output logic        f1f1_o,
    output logic        f1f2_o,
    output logic        hf_o,
    output logic        fh_o,
    output logic        hh_o,
    output logic        stall_compressed_o
);

    align_state_t state_q, state_d;
    logic [15:0]  buf_q, buf_d;
    logic [31:0]  pc_q, pc_d;

    logic [15:0]  lo_s, hi_s;
    logic         valid_s, fire_s;
    logic [4:0]   class_s;   // {f1f1, f1f2, hf, fh, hh}
    logic         stall_s;
    logic [31:0]  instr_s;

    assign lo_s = fetch_data_i[15:0];
    assign hi_s = fetch_data_i[31:16];

    // State, leftover half and PC registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ALIGNED;
            buf_q   <= 16'h0000;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pc_q    <= pc_d;
        end
    end

    // Instruction selection per alignment state
    always_comb begin
        valid_s = 1'b0;
        instr_s = 32'h0000_0000;
        class_s = 5'b00000;
        stall_s = 1'b0;
        case (state_q)
            ALIGNED: begin
                valid_s = fetch_valid_i;
                if (!is_rvc(lo_s)) begin
                    instr_s = fetch_data_i;
                    class_s = 5'b10000;
                end else if (is_rvc(hi_s)) begin
                    instr_s = {16'h0000, lo_s};
                    class_s = 5'b00001;
                end else begin
                    instr_s = {16'h0000, lo_s};
                    class_s = 5'b00100;
                end
            end
            SPAN: begin
                valid_s = fetch_valid_i;
                instr_s = {lo_s, buf_q};
                if (is_rvc(hi_s)) begin
                    class_s = 5'b00010;
                end else begin
                    class_s = 5'b01000;
                end
            end
            HI_COMP: begin
                valid_s = 1'b1;
                instr_s = {16'h0000, buf_q};
                class_s = 5'b00001;
                stall_s = 1'b1;
            end
            SKIP_LO: begin
                // A full upper half only seeds the buffer; nothing is emitted yet
                if (is_rvc(hi_s)) begin
                    valid_s = fetch_valid_i;
                    instr_s = {16'h0000, hi_s};
                    class_s = 5'b00001;
                end else begin
                    valid_s = 1'b0;
                end
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
        if (redirect_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_s;
        end
    end

    assign fire_s = valid_s & instr_ready_i;

    // Next-state, buffer, PC and fetch handshake
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        pc_d          = pc_q;
        fetch_ready_o = 1'b0;
        if (redirect_i) begin
            state_d = redirect_pc_i[1] ? SKIP_LO : ALIGNED;
            buf_d   = 16'h0000;
            pc_d    = redirect_pc_i;
        end else begin
            case (state_q)
                ALIGNED, SPAN: begin
                    fetch_ready_o = fire_s;
                    if (fire_s) begin
                        buf_d = hi_s;
                        if (state_q == ALIGNED && !is_rvc(lo_s)) begin
                            state_d = ALIGNED;
                        end else if (is_rvc(hi_s)) begin
                            state_d = HI_COMP;
                        end else begin
                            state_d = SPAN;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                HI_COMP: begin
                    if (fire_s) begin
                        state_d = ALIGNED;
                    end else begin
                        state_d = state_q;
                    end
                end
                SKIP_LO: begin
                    if (is_rvc(hi_s)) begin
                        fetch_ready_o = fire_s;
                        if (fire_s) begin
                            state_d = ALIGNED;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        fetch_ready_o = fetch_valid_i;
                        if (fetch_valid_i) begin
                            buf_d   = hi_s;
                            state_d = SPAN;
                        end else begin
                            state_d = state_q;
                        end
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
            if (fire_s) begin
                pc_d = pc_q + (is_rvc(instr_s[15:0]) ? 32'd2 : 32'd4);
            end else begin
                pc_d = pc_d;
            end
        end
    end

    assign instr_valid_o         = valid_s;
    assign instr_o               = instr_s;
    assign instr_pc_o            = pc_q;
    assign instr_is_compressed_o = is_rvc(instr_s[15:0]);
    assign f1f1_o                = valid_s & class_s[4];
    assign f1f2_o                = valid_s & class_s[3];
    assign hf_o                  = valid_s & class_s[2];
    assign fh_o                  = valid_s & class_s[1];
    assign hh_o                  = valid_s & class_s[0];
    assign stall_compressed_o    = valid_s & stall_s;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner: hand-computed instructions, PCs and
// alignment classes across aligned, split, spanning, redirect and stall cases.
module tb_rvc_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_compressed;
    logic        f1f1, f1f2, hf, fh, hh;
    logic        stall_compressed;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rvc_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .fetch_valid_i         (fetch_valid),
        .fetch_data_i          (fetch_data),
        .fetch_ready_o         (fetch_ready),
        .redirect_i            (redirect),
        .redirect_pc_i         (redirect_pc),
        .instr_valid_o         (instr_valid),
        .instr_ready_i         (instr_ready),
        .instr_o               (instr),
        .instr_pc_o            (instr_pc),
        .instr_is_compressed_o (instr_is_compressed),
        .f1f1_o                (f1f1),
        .f1f2_o                (f1f2),
        .hf_o                  (hf),
        .fh_o                  (fh),
        .hh_o                  (hh),
        .stall_compressed_o    (stall_compressed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks a presented instruction: {f1f1,f1f2,hf,fh,hh} class vector, stall and fetch_ready.
    task automatic chk_instr(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                             input logic [4:0] e_class, input logic e_stall, input logic e_fready);
        chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, ".instr"}, instr, e_instr);
        chk({tag, ".pc"}, instr_pc, e_pc);
        chk({tag, ".class"}, {27'd0, f1f1, f1f2, hf, fh, hh}, {27'd0, e_class});
        chk({tag, ".stall"}, {31'd0, stall_compressed}, {31'd0, e_stall});
        chk({tag, ".fready"}, {31'd0, fetch_ready}, {31'd0, e_fready});
        chk({tag, ".isc"}, {31'd0, instr_is_compressed}, {31'd0, (e_instr[1:0] != 2'b11)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_data = 32'h0; redirect = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset.valid", {31'd0, instr_valid}, 32'd0);
        chk("reset.pc", instr_pc, 32'h0);
        chk("reset.class", {27'd0, f1f1, f1f2, hf, fh, hh}, 32'd0);

        // Full aligned
        fetch_valid = 1'b1; fetch_data = 32'h0010_0093; #1;
        chk_instr("full", 32'h0010_0093, 32'h0, 5'b10000, 1'b0, 1'b1);
        step();

        // Two compressed in one word
        fetch_data = 32'h4505_4501; #1;
        chk_instr("cc1", 32'h0000_4501, 32'h4, 5'b00001, 1'b0, 1'b1);
        step();
        chk_instr("cc2", 32'h0000_4505, 32'h6, 5'b00001, 1'b1, 1'b0);
        step();

        // Spanning full instruction
        fetch_data = 32'h0093_4501; #1;
        chk_instr("sp1", 32'h0000_4501, 32'h8, 5'b00100, 1'b0, 1'b1);
        step();
        fetch_data = 32'h4505_0010; #1;
        chk_instr("sp2", 32'h0010_0093, 32'hA, 5'b00010, 1'b0, 1'b1);
        step();
        chk_instr("sp3", 32'h0000_4505, 32'hE, 5'b00001, 1'b1, 1'b0);
        step();
        fetch_data = 32'h0000_0013; #1;
        chk_instr("sp4", 32'h0000_0013, 32'h10, 5'b10000, 1'b0, 1'b1);
        step();

        // Redirect to halfword target
        redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
        chk("rd.valid", {31'd0, instr_valid}, 32'd0);
        chk("rd.fready", {31'd0, fetch_ready}, 32'd0);
        step();
        redirect = 1'b0; fetch_data = 32'h4505_4501; #1;
        chk_instr("rdh", 32'h0000_4505, 32'h102, 5'b00001, 1'b0, 1'b1);
        step();
        fetch_data = 32'h0000_0013; #1;
        chk_instr("rdh2", 32'h0000_0013, 32'h104, 5'b10000, 1'b0, 1'b1);
        step();

        // Redirect mid-span
        fetch_data = 32'h0093_4501; #1;
        chk_instr("ms1", 32'h0000_4501, 32'h108, 5'b00100, 1'b0, 1'b1);
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200; fetch_data = 32'h4505_0010; #1;
        chk("ms.valid", {31'd0, instr_valid}, 32'd0);
        step();
        redirect = 1'b0; fetch_data = 32'h0000_0013; #1;
        chk_instr("ms2", 32'h0000_0013, 32'h200, 5'b10000, 1'b0, 1'b1);
        step();

        // Backpressure in SPAN
        fetch_data = 32'h0093_4501; #1;
        chk_instr("bp0", 32'h0000_4501, 32'h204, 5'b00100, 1'b0, 1'b1);
        step();
        fetch_data = 32'h4505_0010; instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_instr("bp.hold", 32'h0010_0093, 32'h206, 5'b00010, 1'b0, 1'b0);
            step();
        end
        instr_ready = 1'b1; #1;
        chk_instr("bp.fire", 32'h0010_0093, 32'h206, 5'b00010, 1'b0, 1'b1);
        step();
        chk_instr("bp.hc", 32'h0000_4505, 32'h20A, 5'b00001, 1'b1, 1'b0);
        step();

        // Redirect to halfword target whose upper half is a full instruction start
        redirect = 1'b1; redirect_pc = 32'h0000_0302; #1;
        step();
        redirect = 1'b0; fetch_data = 32'h0093_4501; #1;
        chk("skf.valid", {31'd0, instr_valid}, 32'd0);
        chk("skf.fready", {31'd0, fetch_ready}, 32'd1);
        step();
        fetch_data = 32'h4505_0010; #1;
        chk_instr("skf2", 32'h0010_0093, 32'h302, 5'b00010, 1'b0, 1'b1);
        step();
        chk_instr("skf3", 32'h0000_4505, 32'h306, 5'b00001, 1'b1, 1'b0);

        // Reset in HI_COMP with a concurrent redirect
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0402;
        step();
        reset = 1'b0; redirect = 1'b0; fetch_valid = 1'b0; #1;
        chk("rst2.valid", {31'd0, instr_valid}, 32'd0);
        chk("rst2.pc", instr_pc, 32'h0);
        fetch_valid = 1'b1; fetch_data = 32'h0000_0013; #1;
        chk_instr("rst2.f", 32'h0000_0013, 32'h0, 5'b10000, 1'b0, 1'b1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
